dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 9, SHALL set the data-memory word address width.
REQ-002 Parameter DATA_W, default 32, SHALL set the data width.
REQ-003 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 reset  input  1  SHALL be the synchronous, active-low reset, sampled on the clk rising edge.
REQ-005 core_req  input  1  SHALL be the datapath load/store request, held high while core_stall=1.
REQ-006 core_we  input  1  SHALL select a write (1) or a read (0) for the core.
REQ-007 core_addr  input  ADDR_W  SHALL be the core word address.
REQ-008 core_wdata  input  DATA_W  SHALL be the core store data.
REQ-009 core_rdata  output  DATA_W  SHALL be the registered core load data.
REQ-010 core_stall  output  1  SHALL freeze the PC and pipeline state of the datapath while high.
REQ-011 host_req  input  1  SHALL be the external host/loader request.
REQ-012 host_we, host_addr, host_wdata  input  1/ADDR_W/DATA_W  SHALL be the host write-enable, address and data.
REQ-013 host_rdata  output  DATA_W  SHALL be the registered host read data.
REQ-014 host_ack  output  1  SHALL be a one-cycle pulse marking host access completion.
REQ-015 mem_re, mem_we  output  1  SHALL be the read and write strobes to the data memory.
REQ-016 mem_addr, mem_wdata  output  ADDR_W/DATA_W  SHALL be the memory address and write data.
REQ-017 mem_rdata  input  DATA_W  SHALL be the memory read data, valid on the cycle after the cycle in which mem_re=1.

Function
REQ-018 FSM states SHALL be IDLE, C_ISS, C_RD, C_DONE, H_ISS, H_RD and H_DONE.
REQ-019 IDLE transitions SHALL be as follows:
- core_req only: go to C_ISS.
- host_req only: go to H_ISS.
- both requests: grant the requester not recorded in last_grant.
- neither request: stay in IDLE.
REQ-020 last_grant SHALL update to the winner on every grant from IDLE; after reset it SHALL hold HOST, so the core wins the first tie.
REQ-021 On the grant edge, the winner's we, addr and wdata SHALL be captured into internal registers; mem_addr and mem_wdata SHALL drive only from these registers.
REQ-022 C_ISS/H_ISS SHALL drive mem_we=captured we and mem_re=~captured we; writes go to C_DONE/H_DONE next, reads go to C_RD/H_RD next.
REQ-023 C_RD/H_RD SHALL load mem_rdata into core_rdata/host_rdata on the exiting edge, then go to C_DONE/H_DONE.
REQ-024 C_DONE and H_DONE SHALL return to IDLE unconditionally; no grant is made from a DONE state.
REQ-025 mem_re and mem_we SHALL be 0 in IDLE, RD and DONE states, and SHALL never be 1 in the same cycle.
REQ-026 core_stall SHALL equal core_req AND (state != C_DONE), including while a host access is in progress.
REQ-027 host_ack SHALL be 1 exactly in H_DONE.
REQ-028 Latency from IDLE with the request present SHALL be:
- write: 3 cycles (IDLE, ISS, DONE).
- read: 4 cycles (IDLE, ISS, RD, DONE).
REQ-029 A requester that drops its req after being granted SHALL have its access completed; the DONE state and host_ack SHALL still occur.
REQ-030 A requester that keeps req high in DONE SHALL be treated as a new request in the following IDLE cycle.
REQ-031 core_rdata SHALL change only on the C_RD exiting edge, and host_rdata only on the H_RD exiting edge; each holds its value otherwise.
REQ-032 Address and data widths SHALL pass through unmodified, with no wrap-around or range checking.

Reset
REQ-033 While reset=0, mem_re and mem_we SHALL be forced to 0 combinationally, including in the reset cycle itself.
REQ-034 The reset edge SHALL set:
- state to IDLE.
- last_grant to HOST.
- core_rdata, host_rdata and the capture registers to 0.
REQ-035 During and after reset, host_ack SHALL be 0 and core_stall SHALL equal core_req.
REQ-036 A reset asserted during C_ISS of a write SHALL prevent that write; a reset during any RD state SHALL discard the read and leave the rdata register at 0.

Verification
REQ-037 Core write: core_req=1, we=1, addr=0x005, wdata=0xDEADBEEF -> mem_we=1 and mem_addr=0x005 in cycle 2; core_stall low in cycle 3; state IDLE in cycle 4.
REQ-038 Core read: the memory holds 0x12345678 at 0x010; core read of 0x010 -> mem_re in cycle 2; core_rdata=0x12345678 with core_stall=0 in cycle 4.
REQ-039 Tie out of reset, both requesting reads: core is granted first and host second; host_ack=1 in cycle 8; core_stall=0 only in cycle 4.
REQ-040 Back-to-back ties with both requests held high: grants alternate as core, host, core, host; no requester waits more than one access.
REQ-041 Host drops host_req in H_ISS of a write to 0x1FF -> the write still occurs and host_ack pulses once.
REQ-042 reset=0 during C_ISS of a core write to 0x003 -> mem_we=0 in that cycle; memory at 0x003 is unchanged; state is IDLE after the edge.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
// Shares one single-port data memory between the datapath (core) and an
// external host/loader. Accesses are serialised through a small FSM; when
// both sides request at the same time from IDLE, the side that was not
// granted last wins, so back-to-back contention alternates fairly.
//
// Ports
//   clk, reset        : clock and synchronous active-low reset
//   core_req/we/addr/wdata, core_rdata, core_stall
//                     : datapath load/store port; core_stall freezes the
//                       datapath until its access reaches C_DONE
//   host_req/we/addr/wdata, host_rdata, host_ack
//                     : host port; host_ack pulses for one cycle on completion
//   mem_re, mem_we, mem_addr, mem_wdata, mem_rdata
//                     : data memory port; mem_rdata is valid one cycle after
//                       the cycle with mem_re=1
module dmem_arbiter #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic [DATA_W-1:0] core_rdata,
  output logic              core_stall,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_ack,
  output logic              mem_re,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    C_ISS  = 3'd1,
    C_RD   = 3'd2,
    C_DONE = 3'd3,
    H_ISS  = 3'd4,
    H_RD   = 3'd5,
    H_DONE = 3'd6
  } state_t;

  state_t            state;
  logic              last_host;   // 1: host was granted last (core wins next tie)
  logic              cap_we;
  logic [ADDR_W-1:0] cap_addr;
  logic [DATA_W-1:0] cap_wdata;
  logic              issuing;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      last_host  <= 1'b1;
      core_rdata <= '0;
      host_rdata <= '0;
      cap_we     <= 1'b0;
      cap_addr   <= '0;
      cap_wdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          // Core wins when alone, or on a tie when the host had the last grant.
          if (core_req && (!host_req || last_host)) begin
            state     <= C_ISS;
            last_host <= 1'b0;
            cap_we    <= core_we;
            cap_addr  <= core_addr;
            cap_wdata <= core_wdata;
          end else if (host_req) begin
            state     <= H_ISS;
            last_host <= 1'b1;
            cap_we    <= host_we;
            cap_addr  <= host_addr;
            cap_wdata <= host_wdata;
          end
        end
        C_ISS:  state <= cap_we ? C_DONE : C_RD;
        C_RD: begin
          core_rdata <= mem_rdata;
          state      <= C_DONE;
        end
        C_DONE: state <= IDLE;
        H_ISS:  state <= cap_we ? H_DONE : H_RD;
        H_RD: begin
          host_rdata <= mem_rdata;
          state      <= H_DONE;
        end
        H_DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Strobes are gated by reset so an access caught in ISS is suppressed
  // within the very cycle reset is asserted.
  assign issuing    = reset && ((state == C_ISS) || (state == H_ISS));
  assign mem_we     = issuing && cap_we;
  assign mem_re     = issuing && !cap_we;
  assign mem_addr   = cap_addr;
  assign mem_wdata  = cap_wdata;

  assign core_stall = core_req && !(reset && (state == C_DONE));
  assign host_ack   = reset && (state == H_DONE);

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;
  localparam int AW = 9;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          core_req, core_we, host_req, host_we;
  logic [AW-1:0] core_addr, host_addr, mem_addr;
  logic [DW-1:0] core_wdata, host_wdata, core_rdata, host_rdata, mem_wdata, mem_rdata;
  logic          core_stall, host_ack, mem_re, mem_we;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_rdata(core_rdata), .core_stall(core_stall),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_rdata(host_rdata), .host_ack(host_ack),
    .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Data memory: one-cycle read latency; preload port used only while idle.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic          pre_en = 1'b0;
  logic [AW-1:0] pre_addr = '0;
  logic [DW-1:0] pre_data = '0;

  always @(posedge clk) begin
    if (pre_en) mem[pre_addr] <= pre_data;
    else if (mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_addr];
  end

  // Reference memory contents for the random test.
  logic [DW-1:0] ref_mem [0:7];
  int            ref_last_host;

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk); pre_en = 1'b1; pre_addr = a; pre_data = d;
    @(negedge clk); pre_en = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1'b0; core_req = 1'b0; host_req = 1'b0;
    @(negedge clk);
    @(negedge clk); reset = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk); reset = 1'b0; core_req = 1'b1; #1;
    total++; if (core_stall !== 1'b1) begin bad++; $display("FAIL rst_stall got=%b want=1", core_stall); end
    total++; if (host_ack !== 1'b0) begin bad++; $display("FAIL rst_ack got=%b want=0", host_ack); end
    total++; if ({mem_re, mem_we} !== 2'b00) begin bad++; $display("FAIL rst_strobes got=%b want=00", {mem_re, mem_we}); end
    @(negedge clk); core_req = 1'b0; #1;
    total++; if (core_rdata !== '0) begin bad++; $display("FAIL rst_core_rdata got=%h want=0", core_rdata); end
    total++; if (host_rdata !== '0) begin bad++; $display("FAIL rst_host_rdata got=%h want=0", host_rdata); end
    total++; if (core_stall !== 1'b0) begin bad++; $display("FAIL rst_stall_low got=%b want=0", core_stall); end
    reset = 1'b1;
  endtask

  task automatic test_core_write();
    @(negedge clk); core_req = 1'b1; core_we = 1'b1; core_addr = 9'h005; core_wdata = 32'hDEADBEEF;
    @(negedge clk);
    total++; if ({mem_we, mem_re} !== 2'b10) begin bad++; $display("FAIL cw_strobes got=%b want=10", {mem_we, mem_re}); end
    total++; if (mem_addr !== 9'h005) begin bad++; $display("FAIL cw_addr got=%h want=005", mem_addr); end
    total++; if (mem_wdata !== 32'hDEADBEEF) begin bad++; $display("FAIL cw_wdata got=%h want=deadbeef", mem_wdata); end
    @(negedge clk);
    total++; if (core_stall !== 1'b0) begin bad++; $display("FAIL cw_stall_c3 got=%b want=0", core_stall); end
    core_req = 1'b0;
    @(negedge clk);
    total++; if ({mem_we, mem_re} !== 2'b00) begin bad++; $display("FAIL cw_c4_strobes got=%b want=00", {mem_we, mem_re}); end
    total++; if (mem[5] !== 32'hDEADBEEF) begin bad++; $display("FAIL cw_mem got=%h want=deadbeef", mem[5]); end
  endtask

  task automatic test_core_read();
    preload(9'h010, 32'h12345678);
    @(negedge clk); core_req = 1'b1; core_we = 1'b0; core_addr = 9'h010;
    @(negedge clk);
    total++; if ({mem_re, mem_we} !== 2'b10) begin bad++; $display("FAIL cr_strobes got=%b want=10", {mem_re, mem_we}); end
    total++; if (core_stall !== 1'b1) begin bad++; $display("FAIL cr_stall_c2 got=%b want=1", core_stall); end
    @(negedge clk);
    total++; if (core_stall !== 1'b1) begin bad++; $display("FAIL cr_stall_c3 got=%b want=1", core_stall); end
    total++; if (core_rdata !== '0) begin bad++; $display("FAIL cr_early_rdata got=%h want=0", core_rdata); end
    @(negedge clk);
    total++; if (core_rdata !== 32'h12345678) begin bad++; $display("FAIL cr_rdata got=%h want=12345678", core_rdata); end
    total++; if (core_stall !== 1'b0) begin bad++; $display("FAIL cr_stall_c4 got=%b want=0", core_stall); end
    core_req = 1'b0;
  endtask

  task automatic test_tie();
    int done_c;
    do_reset();
    preload(9'h020, 32'hAAAA0001);
    preload(9'h021, 32'hBBBB0002);
    @(negedge clk);
    core_req = 1'b1; core_we = 1'b0; core_addr = 9'h020;
    host_req = 1'b1; host_we = 1'b0; host_addr = 9'h021;
    for (int c = 1; c <= 8; c++) begin
      if (c == 1) #1; else @(negedge clk);
      total++; if (core_stall !== (c != 4)) begin bad++; $display("FAIL tie_stall c%0d got=%b want=%b", c, core_stall, c != 4); end
      total++; if (host_ack !== (c == 8)) begin bad++; $display("FAIL tie_ack c%0d got=%b want=%b", c, host_ack, c == 8); end
      if (c == 2) begin
        total++; if (!(mem_re === 1'b1 && mem_addr === 9'h020)) begin bad++; $display("FAIL tie_grant1 got re=%b addr=%h want re=1 addr=020", mem_re, mem_addr); end
      end
      if (c == 4) begin
        total++; if (core_rdata !== 32'hAAAA0001) begin bad++; $display("FAIL tie_core_rdata got=%h want=aaaa0001", core_rdata); end
      end
      if (c == 6) begin
        total++; if (!(mem_re === 1'b1 && mem_addr === 9'h021)) begin bad++; $display("FAIL tie_grant2 got re=%b addr=%h want re=1 addr=021", mem_re, mem_addr); end
      end
      if (c == 8) begin
        total++; if (host_rdata !== 32'hBBBB0002) begin bad++; $display("FAIL tie_host_rdata got=%h want=bbbb0002", host_rdata); end
        host_req = 1'b0;
      end
    end
    // Core kept its request high, so it is re-served right after the host.
    done_c = 0;
    for (int c = 9; c <= 20 && done_c == 0; c++) begin
      @(negedge clk);
      if (!core_stall) begin done_c = c; core_req = 1'b0; end
    end
    total++; if (done_c != 12) begin bad++; $display("FAIL tie_core_again got=%0d want=12", done_c); end
  endtask

  task automatic test_back_to_back();
    int grants[$];
    do_reset();
    @(negedge clk);
    core_req = 1'b1; core_we = 1'b0; core_addr = 9'h030;
    host_req = 1'b1; host_we = 1'b0; host_addr = 9'h031;
    for (int c = 2; c <= 40; c++) begin
      @(negedge clk);
      if (mem_re) grants.push_back(mem_addr == 9'h030 ? 0 : 1);
    end
    total++; if (grants.size() < 8) begin bad++; $display("FAIL b2b_count got=%0d want>=8", grants.size()); end
    for (int i = 0; i < 8 && i < grants.size(); i++) begin
      total++; if (grants[i] != i % 2) begin bad++; $display("FAIL b2b_order idx%0d got=%0d want=%0d", i, grants[i], i % 2); end
    end
    do_reset();
  endtask

  task automatic test_host_drop();
    int acks;
    @(negedge clk); host_req = 1'b1; host_we = 1'b1; host_addr = 9'h1FF; host_wdata = 32'hC0FFEE01;
    @(negedge clk); host_req = 1'b0;
    total++; if (!(mem_we === 1'b1 && mem_addr === 9'h1FF && mem_wdata === 32'hC0FFEE01)) begin
      bad++; $display("FAIL hd_write got we=%b addr=%h data=%h want we=1 addr=1ff data=c0ffee01", mem_we, mem_addr, mem_wdata);
    end
    acks = 0;
    for (int c = 3; c <= 8; c++) begin
      @(negedge clk);
      if (host_ack) acks++;
    end
    total++; if (acks != 1) begin bad++; $display("FAIL hd_acks got=%0d want=1", acks); end
    total++; if (mem[9'h1FF] !== 32'hC0FFEE01) begin bad++; $display("FAIL hd_mem got=%h want=c0ffee01", mem[9'h1FF]); end
  endtask

  task automatic test_reset_midway();
    preload(9'h003, 32'hA5A5A5A5);
    preload(9'h011, 32'h55555555);
    // Reset in C_ISS of a write
    @(negedge clk); core_req = 1'b1; core_we = 1'b1; core_addr = 9'h003; core_wdata = 32'h11111111;
    @(negedge clk); reset = 1'b0; #1;
    total++; if ({mem_we, mem_re} !== 2'b00) begin bad++; $display("FAIL rm_strobes got=%b want=00", {mem_we, mem_re}); end
    @(negedge clk); reset = 1'b1; core_req = 1'b0;
    @(negedge clk);
    total++; if ({mem_we, mem_re, host_ack, core_stall} !== 4'b0000) begin bad++; $display("FAIL rm_idle got=%b want=0000", {mem_we, mem_re, host_ack, core_stall}); end
    total++; if (mem[3] !== 32'hA5A5A5A5) begin bad++; $display("FAIL rm_mem got=%h want=a5a5a5a5", mem[3]); end
    // Complete a read so core_rdata is non-zero, then reset in C_RD of the next
    @(negedge clk); core_req = 1'b1; core_we = 1'b0; core_addr = 9'h010;
    @(negedge clk); @(negedge clk); @(negedge clk);
    total++; if (core_rdata !== 32'h12345678) begin bad++; $display("FAIL rm_pre_rdata got=%h want=12345678", core_rdata); end
    core_req = 1'b0;
    @(negedge clk); core_req = 1'b1; core_addr = 9'h011;
    @(negedge clk);
    @(negedge clk); reset = 1'b0;
    @(negedge clk); reset = 1'b1; core_req = 1'b0; #1;
    total++; if (core_rdata !== '0) begin bad++; $display("FAIL rm_rd_discard got=%h want=0", core_rdata); end
  endtask

  task automatic test_random();
    do_reset();
    ref_last_host = 1;
    for (int i = 0; i < 8; i++) begin
      ref_mem[i] = $urandom;
      preload(AW'(9'h040 + i), ref_mem[i]);
    end
    for (int r = 0; r < 40; r++) begin
      int mode, first_core, c_exp_done, h_exp_done, c_done, h_done, t, acks;
      logic cw, hw, cp, hp;
      logic [2:0] ci, hi;
      logic [DW-1:0] cd, hd, c_exp, h_exp, c_got, h_got;
      mode = $urandom_range(1, 3);
      cw = 1'($urandom_range(0, 1)); ci = 3'($urandom_range(0, 7)); cd = $urandom;
      hw = 1'($urandom_range(0, 1)); hi = 3'($urandom_range(0, 7)); hd = $urandom;
      cp = (mode != 2); hp = (mode != 1);
      first_core = (mode == 1) || (mode == 3 && ref_last_host == 1);
      // Serve accesses in grant order against the reference memory.
      t = 0; c_exp = '0; h_exp = '0; c_exp_done = 0; h_exp_done = 0;
      for (int k = 0; k < 2; k++) begin
        if ((k == 0) == (first_core != 0)) begin
          if (cp) begin
            t += cw ? 3 : 4; c_exp_done = t;
            if (cw) ref_mem[ci] = cd; else c_exp = ref_mem[ci];
            ref_last_host = 0;
          end
        end else if (hp) begin
          t += hw ? 3 : 4; h_exp_done = t;
          if (hw) ref_mem[hi] = hd; else h_exp = ref_mem[hi];
          ref_last_host = 1;
        end
      end
      @(negedge clk);
      core_req = cp; core_we = cw; core_addr = AW'(9'h040 + ci); core_wdata = cd;
      host_req = hp; host_we = hw; host_addr = AW'(9'h040 + hi); host_wdata = hd;
      c_done = 0; h_done = 0; acks = 0; c_got = '0; h_got = '0;
      for (int c = 2; c <= 20 && (cp || hp); c++) begin
        @(negedge clk);
        total++; if ((mem_re & mem_we) !== 1'b0) begin bad++; $display("FAIL rnd_both_strobes r%0d c%0d got=1 want=0", r, c); end
        if (host_ack) acks++;
        if (cp && !core_stall) begin c_done = c; c_got = core_rdata; core_req = 1'b0; cp = 1'b0; end
        if (hp && host_ack) begin h_done = c; h_got = host_rdata; host_req = 1'b0; hp = 1'b0; end
      end
      if (cp || hp) begin
        total++; bad++; $display("FAIL rnd_timeout r%0d core_pending=%b host_pending=%b", r, cp, hp);
        core_req = 1'b0; host_req = 1'b0;
        do_reset();
        ref_last_host = 1;
        continue;
      end
      if (mode != 2) begin
        total++; if (c_done != c_exp_done) begin bad++; $display("FAIL rnd_core_lat r%0d got=%0d want=%0d", r, c_done, c_exp_done); end
        if (!cw) begin
          total++; if (c_got !== c_exp) begin bad++; $display("FAIL rnd_core_data r%0d got=%h want=%h", r, c_got, c_exp); end
        end
      end
      if (mode != 1) begin
        total++; if (h_done != h_exp_done) begin bad++; $display("FAIL rnd_host_lat r%0d got=%0d want=%0d", r, h_done, h_exp_done); end
        total++; if (acks != 1) begin bad++; $display("FAIL rnd_host_acks r%0d got=%0d want=1", r, acks); end
        if (!hw) begin
          total++; if (h_got !== h_exp) begin bad++; $display("FAIL rnd_host_data r%0d got=%h want=%h", r, h_got, h_exp); end
        end
      end
    end
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      total++; if (mem[9'h040 + i] !== ref_mem[i]) begin bad++; $display("FAIL rnd_final_mem idx%0d got=%h want=%h", i, mem[9'h040 + i], ref_mem[i]); end
    end
  endtask

  initial begin
    reset = 1'b0;
    core_req = 1'b0; core_we = 1'b0; core_addr = '0; core_wdata = '0;
    host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
    @(negedge clk);
    test_reset();
    test_core_write();
    test_core_read();
    test_tie();
    test_back_to_back();
    test_host_drop();
    test_reset_midway();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1, "timeout");
  end
endmodule
